// File: rtl/valid_ready_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : valid_ready_pkg
//  Purpose  : Shared types and helpers for valid/ready stream arbiters.
//             - arb_state_e : arbiter FSM state encoding
//             - rr_pick()   : round-robin selection of the next requester
//  Revision : 1.0  initial release
// ============================================================================
package valid_ready_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Widest request vector rr_pick() understands; callers zero-pad to this.
  localparam int RR_MAX_REQ = 32;
  localparam int RR_IDX_W   = 5;

  // Scan last+1 .. last+num (mod num) and return the first set request.
  // Returns 'last' when nothing is requesting. 'last' must be < num.
  function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                          input int unsigned           last,
                                          input int unsigned           num);
    int unsigned         pick;
    logic                found;
    logic [RR_IDX_W:0]   idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
      // last < num and k <= num, so one conditional subtract is a full modulo.
      idx = (RR_IDX_W+1)'(last) + (RR_IDX_W+1)'(k);
      if (idx >= (RR_IDX_W+1)'(num)) idx = idx - (RR_IDX_W+1)'(num);
      if (!found && (k <= num) && req[idx[RR_IDX_W-1:0]]) begin
        pick  = int'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/valid_ready_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : valid_ready_std_if
//  Purpose  : Standard valid/ready stream bundle.
//  Ports    : valid, ready, data[DATAWIDTH]
//             modport in  : consumer view (valid/data in, ready out)
//             modport out : producer view (valid/data out, ready in)
//  Revision : 1.0  initial release
// ============================================================================
interface valid_ready_std_if #(
  parameter int DATAWIDTH = 8
);
  logic                 valid;
  logic                 ready;
  logic [DATAWIDTH-1:0] data;

  modport in  (input  valid, input  data, output ready);
  modport out (output valid, output data, input  ready);
endinterface
`default_nettype wire

// File: rtl/valid_ready_rr_arbiter_fifo2.sv
`default_nettype none
// ============================================================================
//  Module   : valid_ready_fifo2
//  Purpose  : Two-entry registered stream buffer.
//  Ports    : clk, rst_n      clock, async active-low reset
//             wr_if (.in)     write side; ready = space available
//             rd_if (.out)    read side; valid = not empty, data = head entry
//             count[1:0]      registered fill level (0..2)
//  Revision : 1.0  initial release
// ============================================================================
module valid_ready_fifo2 #(
  parameter int DATAWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  valid_ready_std_if.in     wr_if,
  valid_ready_std_if.out    rd_if,
  output logic [1:0]        count
);

  logic [DATAWIDTH-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic                 push;
  logic                 pop;

  assign wr_if.ready = (count != 2'd2);
  assign rd_if.valid = (count != 2'd0);
  assign rd_if.data  = mem[rd_ptr];

  assign push = wr_if.valid && wr_if.ready;
  assign pop  = rd_if.valid && rd_if.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_if.data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/valid_ready_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : valid_ready_rr_arbiter
//  Purpose  : Round-robin arbiter and mux sharing one downstream stream
//             between NUM_IN upstream requesters, up to BURST_LEN beats per
//             grant, output registered through a 2-entry buffer.
//  Ports    : clk, rst_n              clock, async active-low reset
//             in_if[NUM_IN] (.in)     upstream requesters
//             out_if (.out)           downstream stream
//             grant_valid             1 while in GRANT
//             grant_id                current/last owner index
//  Revision : 1.0  initial release
// ============================================================================
module valid_ready_rr_arbiter
  import valid_ready_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NUM_IN    = 4,   // 2 .. RR_MAX_REQ
  parameter int BURST_LEN = 4    // >= 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  valid_ready_std_if.in             in_if [NUM_IN],
  valid_ready_std_if.out            out_if,
  output logic                      grant_valid,
  output logic [$clog2(NUM_IN)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int BCW   = $clog2(BURST_LEN + 1);

  // Flatten the interface array; interface arrays only take constant indices.
  logic [NUM_IN-1:0]    req;
  logic [DATAWIDTH-1:0] in_data [NUM_IN];
  logic [NUM_IN-1:0]    ready_vec;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    assign req[g]         = in_if[g].valid;
    assign in_data[g]     = in_if[g].data;
    assign in_if[g].ready = ready_vec[g];
  end

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] last_owner, last_nxt;
  logic [BCW-1:0]   beat_cnt, beat_nxt;
  logic [IDX_W-1:0] pick;
  logic [RR_MAX_REQ-1:0] req_pad;

  logic [1:0] fifo_count;
  logic       can_accept;
  logic       owner_valid;
  logic       accepted;

  valid_ready_std_if #(.DATAWIDTH(DATAWIDTH)) push_if ();

  valid_ready_fifo2 #(.DATAWIDTH(DATAWIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_if (push_if),
    .rd_if (out_if),
    .count (fifo_count)
  );

  // Ready comes from the registered fill level, so there is no
  // combinational path from out_if.ready back to any in_if.ready.
  assign can_accept  = (fifo_count != 2'd2);
  assign owner_valid = req[owner];

  assign push_if.valid = (state == GRANT) && owner_valid && can_accept;
  assign push_if.data  = in_data[owner];
  assign accepted      = push_if.valid && push_if.ready;

  always_comb begin
    ready_vec = '0;
    if (state == GRANT && can_accept) ready_vec[owner] = 1'b1;
  end

  always_comb begin
    req_pad             = '0;
    req_pad[NUM_IN-1:0] = req;
    pick = IDX_W'(rr_pick(req_pad, 32'(last_owner), $unsigned(NUM_IN)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_IN - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

  // IDLE never accepts a beat: each arbitration costs one bubble cycle.
  // A backpressured GRANT holds beat_cnt and keeps the grant while the
  // owner stays valid.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          last_nxt  = pick;
          beat_nxt  = '0;
        end
      end
      GRANT: begin
        if (!owner_valid) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else if (accepted) begin
          if (beat_cnt == BCW'(BURST_LEN - 1)) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_cnt + BCW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_valid = (state == GRANT);
  assign grant_id    = owner;

endmodule
`default_nettype wire
